tdp_ram36k_port_ctrl: RTL

//  Requester for one port of a TDP_RAM36K. Turns a valid/ready request stream into

---
 rtl/tdp_ram36k_port_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/tdp_ram36k_port_ctrl.sv
// -----------------------------------------------------------------------------
// tdp_ram36k_port_ctrl
//   Requester for one port (A or B) of a TDP_RAM36K. A valid/ready request
//   stream becomes registered WEN/REN/BE/ADDR/WDATA/WPARITY strobes. Read data
//   comes back on a valid/ready response stream through a 4-entry FIFO. The
//   FIFO is credit-limited, so it never overflows. After reset the block can
//   optionally sweep the whole RAM to zero.
//
//   Parameters: WIDTH (9/18/36), CLEAR_ON_RESET (0/1)
//   Optional feature: define BRAM_PARITY_GEN_EN to generate even write parity
//   from the data and to flag read parity mismatches on rsp_par_err. When it is
//   undefined, req_wpar passes straight through and rsp_par_err is 0.
//
//   Ports
//     CLK, RESET                  clock, synchronous active-high reset
//     req_valid/req_ready         request handshake
//     req_we                      1 = write, 0 = read
//     req_addr                    word address (AW bits)
//     req_wdata, req_wpar         write data and write parity
//     req_be                      byte enables
//     rsp_valid/rsp_ready         read response handshake
//     rsp_data, rsp_parity        read data and read parity (unused lanes are 0)
//     rsp_par_err                 parity mismatch on this response
//     busy                        clear sweep in progress
//     WEN, REN, BE, ADDR          RAM strobes (registered)
//     WDATA, WPARITY              RAM write data and write parity (registered)
//     RDATA, RPARITY              RAM read data and read parity
// -----------------------------------------------------------------------------
module tdp_ram36k_port_ctrl #(
   parameter  int WIDTH          = 36,
   parameter  int CLEAR_ON_RESET = 0,
   localparam int AW             = (WIDTH == 9) ? 12 : (WIDTH == 18) ? 11 : 10,
   localparam int NB             = WIDTH / 9
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   input  logic [3:0]    req_wpar,
   input  logic [3:0]    req_be,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_data,
   output logic [3:0]    rsp_parity,
   output logic          rsp_par_err,
   output logic          busy,
   output logic          WEN,
   output logic          REN,
   output logic [3:0]    BE,
   output logic [14:0]   ADDR,
   output logic [31:0]   WDATA,
   output logic [3:0]    WPARITY,
   input  logic [31:0]   RDATA,
   input  logic [3:0]    RPARITY
);

   localparam logic [31:0] DMASK = (NB == 4) ? 32'hFFFF_FFFF :
                                   (NB == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
   localparam logic [3:0]  PMASK = (NB == 4) ? 4'hF : (NB == 2) ? 4'h3 : 4'h1;

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t          r_state, w_state_nxt;
   logic [AW-1:0]   r_clr_addr;
   logic            r_wen, r_ren, r_rd_s2;
   logic [3:0]      r_be, r_wpar;
   logic [AW-1:0]   r_addr;
   logic [31:0]     r_wdata;
   logic [31:0]     r_fd [4];
   logic [3:0]      r_fp [4];
   logic            r_fe [4];
   logic [1:0]      r_wp, r_rp;
   logic [2:0]      r_cnt;

   logic [2:0]      w_credits;
   logic            w_acc, w_pop;
   logic [3:0]      w_be, w_wpar, w_rpar;
   logic [31:0]     w_wdata, w_rdata;
   logic            w_perr;

   // ---------------- FSM ----------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
         r_clr_addr <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_CLEAR && r_clr_addr == {AW{1'b1}}) w_state_nxt = S_RUN;
   end

   assign busy = (r_state == S_CLEAR);

   // A read owns a credit from acceptance until its response is popped:
   // first in the strobe stage, then in the RDATA stage, then in the FIFO.
   assign w_credits = r_cnt + {2'b00, r_ren} + {2'b00, r_rd_s2};
   assign req_ready = !RESET && (r_state == S_RUN) && (w_credits < 3'd4);
   assign w_acc     = req_valid && req_ready;

   // ---------------- lane mapping ----------------
   always_comb begin
      w_be = 4'hF;
      if (WIDTH == 36)      w_be = req_be;
      else if (WIDTH == 18) w_be = {req_be[1:0], req_be[1:0]};
   end

   assign w_wdata = req_wdata & DMASK;
   assign w_rdata = RDATA & DMASK;
   assign w_rpar  = RPARITY & PMASK;

`ifdef BRAM_PARITY_GEN_EN
   logic w_unused_wpar;
   assign w_unused_wpar = ^req_wpar;
   always_comb begin
      w_wpar = 4'h0;
      w_perr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w_wpar[i] = ^w_wdata[8*i +: 8];
         // Unused lanes are masked to zero, so both sides agree there.
         if (w_rpar[i] != ^w_rdata[8*i +: 8]) w_perr = 1'b1;
      end
   end
`else
   assign w_wpar = req_wpar & PMASK;
   assign w_perr = 1'b0;
`endif

   // ---------------- RAM strobes ----------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_wen   <= 1'b0;
         r_ren   <= 1'b0;
         r_be    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wpar  <= '0;
      end else begin
         r_wen <= 1'b0;
         r_ren <= 1'b0;
         if (r_state == S_CLEAR) begin
            r_wen   <= 1'b1;
            r_be    <= 4'hF;
            r_addr  <= r_clr_addr;
            r_wdata <= '0;
            r_wpar  <= '0;
         end else if (w_acc) begin
            r_wen   <= req_we;
            r_ren   <= !req_we;
            r_be    <= w_be;
            r_addr  <= req_addr;
            r_wdata <= w_wdata;
            r_wpar  <= w_wpar;
         end
      end
   end

   assign WEN     = r_wen;
   assign REN     = r_ren;
   assign BE      = r_be;
   assign ADDR    = {r_addr, {(15-AW){1'b0}}};
   assign WDATA   = r_wdata;
   assign WPARITY = r_wpar;

   // ---------------- response FIFO ----------------
   // RDATA is only meaningful in the cycle after REN was high.
   assign w_pop = rsp_valid && rsp_ready;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_rd_s2 <= 1'b0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
      end else begin
         r_rd_s2 <= r_ren;
         if (r_rd_s2) begin
            r_fd[r_wp] <= w_rdata;
            r_fp[r_wp] <= w_rpar;
            r_fe[r_wp] <= w_perr;
            r_wp       <= r_wp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + {2'b00, r_rd_s2} - {2'b00, w_pop};
      end
   end

   assign rsp_valid   = (r_cnt != 3'd0);
   assign rsp_data    = rsp_valid ? r_fd[r_rp] : '0;
   assign rsp_parity  = rsp_valid ? r_fp[r_rp] : '0;
   assign rsp_par_err = rsp_valid ? r_fe[r_rp] : 1'b0;

endmodule
